// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous VRAM between a display
// fetch stream (one-cycle strobes) and a CPU request/ack port.
// Video has priority over a waiting CPU access until the CPU has been held
// off for 15 consecutive cycles, after which the CPU access goes out and the
// colliding video fetch is dropped (vid_miss).
// Optional build macro: VRAM_POSTED_WRITE_EN -- CPU writes are acknowledged
// the cycle after they are latched and drained from the latch register.
module vram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              pixel_clock,
  input  logic              reset,
  input  logic              vid_rd,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  output logic              vid_miss,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, DATA, DONE} state_t;

  state_t            r_state;
  logic [3:0]        r_starve;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic              r_vid_pend;
  logic              r_vid_valid;
  logic [DATA_W-1:0] r_vid_data;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_cpu_ack;

  logic              w_cpu_issue;
  logic              w_vid_issue;

  // CPU takes the port in ISSUE when video is quiet or has starved it 15 times
  assign w_cpu_issue = (r_state == ISSUE) && (!vid_rd || (r_starve == 4'd15));
  assign w_vid_issue = vid_rd && !w_cpu_issue;

  assign vid_data  = r_vid_data;
  assign vid_valid = r_vid_valid;
  assign cpu_rdata = r_cpu_rdata;
  assign cpu_ack   = r_cpu_ack;

  // RAM port mux; forced idle while reset is held
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    vid_miss  = 1'b0;
    if (!reset) begin
      if (w_cpu_issue) begin
        ram_addr  = r_addr;
        ram_we    = r_we;
        ram_wdata = r_we ? r_wdata : '0;
        vid_miss  = vid_rd;
      end else if (w_vid_issue) begin
        ram_addr  = vid_addr;
      end
    end
  end

  // Video capture: data returns the cycle after issue and is registered there
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_vid_pend  <= 1'b0;
      r_vid_valid <= 1'b0;
      r_vid_data  <= '0;
    end else begin
      r_vid_pend  <= w_vid_issue;
      r_vid_valid <= r_vid_pend;
      if (r_vid_pend) begin
        r_vid_data <= ram_rdata;
      end
    end
  end

  // CPU access FSM with starvation counter and registered ack/read data
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_starve    <= '0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_cpu_ack   <= 1'b0;
    end else begin
      r_cpu_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cpu_req) begin
            r_addr  <= cpu_addr;
            r_we    <= cpu_we;
            r_wdata <= cpu_wdata;
            r_state <= ISSUE;
`ifdef VRAM_POSTED_WRITE_EN
            // posted write: the latch register is the one-entry buffer
            r_cpu_ack <= cpu_we;
`endif
          end
        end
        ISSUE: begin
          if (w_cpu_issue) begin
            r_starve <= '0;
            if (r_we) begin
`ifdef VRAM_POSTED_WRITE_EN
              r_state <= IDLE;
`else
              r_state   <= DONE;
              r_cpu_ack <= 1'b1;
`endif
            end else begin
              r_state <= DATA;
            end
          end else begin
            r_starve <= r_starve + 4'd1;
          end
        end
        DATA: begin
          r_cpu_rdata <= ram_rdata;
          r_cpu_ack   <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: random video/CPU traffic against an
// event-scheduling reference model, plus directed boundary scenarios.
// Build with +define+VRAM_POSTED_WRITE_EN to check the posted-write variant.
module tb_vram_arbiter;

  localparam int NC = 8192;

`ifdef VRAM_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        pixel_clock = 1'b0;
  logic        reset = 1'b1;
  logic        vid_rd = 1'b0;
  logic [12:0] vid_addr = '0;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic        vid_miss;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [12:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  vram_arbiter #(.ADDR_W(13), .DATA_W(8)) dut (
    .pixel_clock(pixel_clock), .reset(reset),
    .vid_rd(vid_rd), .vid_addr(vid_addr), .vid_data(vid_data),
    .vid_valid(vid_valid), .vid_miss(vid_miss),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 pixel_clock = ~pixel_clock;

  // Synchronous single-port RAM
  logic [7:0] mem [NC];
  always @(posedge pixel_clock) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: expected contents plus per-cycle scheduled events
  logic [7:0] ref_mem [NC];
  bit         e_valid [NC];
  logic [7:0] e_vdata [NC];
  bit         e_ack   [NC];
  bit         e_rupd  [NC];
  logic [7:0] e_rval  [NC];
  logic [7:0] cur_vdata = '0;
  logic [7:0] cur_rdata = '0;
  bit         m_pend = 1'b0;
  int         m_acc = 0;
  int         m_free = 0;
  int         m_wins = 0;
  bit         m_we;
  logic [12:0] m_addr;
  logic [7:0]  m_wdata;

  typedef struct {
    bit          we;
    logic [12:0] addr;
    logic [7:0]  wdata;
  } tx_t;
  tx_t txq[$];

  logic [12:0] obs_addr;
  logic        obs_we, obs_miss, obs_ack, obs_valid;
  logic [7:0]  obs_rdata, obs_vdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic poke(input logic [12:0] a, input logic [7:0] d);
    mem[a] <= d;
    ref_mem[a] = d;
  endtask

  // One clock cycle: drive inputs, check DUT against the model, advance model
  task automatic step(input bit vrd, input logic [12:0] vaddr);
    tx_t t;
    bit cgo;
    logic [12:0] xa;
    logic xw, xm;
    logic [7:0] xd;
    @(negedge pixel_clock);
    if (cpu_ack === 1'b1) begin
      cpu_req = 1'b0;
    end else if (!cpu_req && txq.size() > 0) begin
      t = txq.pop_front();
      cpu_req = 1'b1; cpu_we = t.we; cpu_addr = t.addr; cpu_wdata = t.wdata;
    end
    vid_rd = vrd;
    vid_addr = vaddr;
    #1;
    if (e_rupd[cyc]) cur_rdata = e_rval[cyc];
    if (e_valid[cyc]) cur_vdata = e_vdata[cyc];
    check("vid_valid", 32'(vid_valid), 32'(e_valid[cyc]));
    check("vid_data",  32'(vid_data),  32'(cur_vdata));
    check("cpu_ack",   32'(cpu_ack),   32'(e_ack[cyc]));
    check("cpu_rdata", 32'(cpu_rdata), 32'(cur_rdata));
    cgo = 1'b0; xa = '0; xw = 1'b0; xd = '0; xm = 1'b0;
    if (m_pend && cyc > m_acc) begin
      if (!vrd || m_wins == 15) cgo = 1'b1;
      else m_wins++;
    end
    if (cgo) begin
      xa = m_addr; xw = m_we; xd = m_we ? m_wdata : 8'h00; xm = vrd;
      m_pend = 1'b0;
      if (m_we) begin
        ref_mem[m_addr] = m_wdata;
        if (POSTED) m_free = cyc + 1;
        else begin e_ack[cyc+1] = 1'b1; m_free = cyc + 2; end
      end else begin
        e_rupd[cyc+2] = 1'b1; e_rval[cyc+2] = ref_mem[m_addr];
        e_ack[cyc+2] = 1'b1; m_free = cyc + 3;
      end
    end else if (vrd) begin
      xa = vaddr;
      e_valid[cyc+2] = 1'b1; e_vdata[cyc+2] = ref_mem[vaddr];
    end
    if (!m_pend && cyc >= m_free && cpu_req) begin
      m_pend = 1'b1; m_acc = cyc; m_wins = 0;
      m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata;
      if (POSTED && cpu_we) e_ack[cyc+1] = 1'b1;
    end
    check("ram_addr",  32'(ram_addr),  32'(xa));
    check("ram_we",    32'(ram_we),    32'(xw));
    check("ram_wdata", 32'(ram_wdata), 32'(xd));
    check("vid_miss",  32'(vid_miss),  32'(xm));
    obs_addr = ram_addr; obs_we = ram_we; obs_miss = vid_miss; obs_ack = cpu_ack;
    obs_valid = vid_valid; obs_rdata = cpu_rdata; obs_vdata = vid_data;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 13'h0);
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_ram_we"},    32'(ram_we),    32'h0);
    check({tag, "_ram_addr"},  32'(ram_addr),  32'h0);
    check({tag, "_ram_wdata"}, 32'(ram_wdata), 32'h0);
    check({tag, "_vid_valid"}, 32'(vid_valid), 32'h0);
    check({tag, "_vid_data"},  32'(vid_data),  32'h0);
    check({tag, "_vid_miss"},  32'(vid_miss),  32'h0);
    check({tag, "_cpu_ack"},   32'(cpu_ack),   32'h0);
    check({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'h0);
  endtask

  task automatic do_reset(input int n);
    @(negedge pixel_clock);
    reset = 1'b1; cpu_req = 1'b0; vid_rd = 1'b1; vid_addr = 13'h1ABC;
    #1;
    all_zero("rst");
    repeat (n) @(negedge pixel_clock);
    #1;
    all_zero("rst_hold");
    vid_rd = 1'b0; reset = 1'b0;
    m_pend = 1'b0; m_free = 0; cur_vdata = '0; cur_rdata = '0;
    for (int i = cyc; i < cyc + 4; i++) begin
      e_valid[i] = 1'b0; e_ack[i] = 1'b0; e_rupd[i] = 1'b0;
    end
    txq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bias, wecnt, misscnt, westep, ackcnt;
    int we_c[$];
    int ack_c[$];
    logic [7:0] d;
    for (int i = 0; i < NC; i++) begin
      d = 8'($urandom);
      mem[i] <= d;
      ref_mem[i] = d;
    end
    do_reset(2);

    // Randomized traffic with varying video load and mid-run resets
    bias = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        case ($urandom_range(0, 2))
          0: bias = 30;
          1: bias = 70;
          default: bias = 97;
        endcase
      end
      if (txq.size() == 0 && !cpu_req && $urandom_range(0, 3) == 0)
        txq.push_back('{we: 1'($urandom_range(0, 1)), addr: 13'($urandom_range(0, NC-1)),
                        wdata: 8'($urandom)});
      if (i == 700 || i == 1200) do_reset(2);
      step($urandom_range(0, 99) < bias, 13'($urandom_range(0, NC-1)));
    end
    idle(10);

    // CPU read with idle video
    poke(13'h0123, 8'h5A);
    txq.push_back('{we: 1'b0, addr: 13'h0123, wdata: 8'h00});
    step(1'b0, 13'h0);
    check("r36_latch_no_access", 32'(obs_addr), 32'h0);
    step(1'b0, 13'h0);
    check("r36_issue_addr", 32'(obs_addr), 32'h0123);
    step(1'b0, 13'h0);
    step(1'b0, 13'h0);
    check("r36_ack", 32'(obs_ack), 32'h1);
    check("r36_rdata", 32'(obs_rdata), 32'h5A);
    idle(3);

    // Video fetch collides with ISSUE
    poke(13'h1FFF, 8'hC3);
    txq.push_back('{we: 1'b0, addr: 13'h0055, wdata: 8'h00});
    step(1'b0, 13'h0);
    step(1'b1, 13'h1FFF);
    check("r37_video_first", 32'(obs_addr), 32'h1FFF);
    step(1'b0, 13'h0);
    check("r37_cpu_next", 32'(obs_addr), 32'h0055);
    step(1'b0, 13'h0);
    check("r37_vid_valid", 32'(obs_valid), 32'h1);
    check("r37_vid_data", 32'(obs_vdata), 32'hC3);
    idle(4);

    // Starvation limit: continuous video with a pending write
    txq.push_back('{we: 1'b1, addr: 13'h0200, wdata: 8'h77});
    wecnt = 0; misscnt = 0; westep = -1;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 13'($urandom_range(0, NC-1)));
      if (obs_we) begin wecnt++; westep = k; end
      if (obs_miss) misscnt++;
    end
    check("r38_we_count", 32'(wecnt), 32'd1);
    check("r38_miss_count", 32'(misscnt), 32'd1);
    check("r38_issue_step", 32'(westep), 32'd16);
    idle(4);
    check("r38_stored", 32'(mem[13'h0200]), 32'h77);

    // Reset while a write waits in ISSUE
    poke(13'h0400, 8'h00);
    txq.push_back('{we: 1'b1, addr: 13'h0400, wdata: 8'hEE});
    step(1'b1, 13'h0001);
    step(1'b1, 13'h0002);
    do_reset(2);
    wecnt = 0; ackcnt = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 13'h0);
      if (obs_we) wecnt++;
      if (obs_ack) ackcnt++;
    end
    check("r39_no_write", 32'(wecnt), 32'd0);
    check("r39_no_ack", 32'(ackcnt), 32'd0);
    check("r39_mem_kept", 32'(mem[13'h0400]), 32'h00);

    // Back-to-back writes
    txq.push_back('{we: 1'b1, addr: 13'h0010, wdata: 8'h11});
    txq.push_back('{we: 1'b1, addr: 13'h0011, wdata: 8'h22});
    for (int k = 0; k < 9; k++) begin
      step(1'b0, 13'h0);
      if (obs_we) we_c.push_back(k);
      if (obs_ack) ack_c.push_back(k);
    end
    check("r40_we_count", 32'(we_c.size()), 32'd2);
    check("r40_ack_count", 32'(ack_c.size()), 32'd2);
    if (we_c.size() == 2 && ack_c.size() == 2) begin
      for (int k = 0; k < 2; k++)
        check("r40_ack_timing", 32'(ack_c[k]), 32'(we_c[k] + (POSTED ? 0 : 1)));
    end
    idle(2);
    check("r40_mem10", 32'(mem[13'h0010]), 32'h11);
    check("r40_mem11", 32'(mem[13'h0011]), 32'h22);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
